pipe_stage_skid: RTL and testbench

- Parametrised, generic inter-stage pipeline register for the CPU pipeline (IF/ID … MEM/WB). It replaces the hand-written per-stage register modules.
- Adds a valid/ready handshake, a two-entry skid buffer (registered in_ready, no combinational ready path) and a synchronous flush.
- Control bits and data are separate fields. Control bits are forced to zero whenever a slot is a bubble, so a squashed instruction can never write registers or memory.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 56 +++++
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 tb/tb_pipe_stage_skid.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : occupancy encodings and per-stage widths for pipe_stage_skid
// Rev 1.0
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int IFID_CTRL_W  = 4;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 144;
    localparam int EXMEM_CTRL_W = 6;
    localparam int EXMEM_DATA_W = 104;
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 96;

    // The skid slot is only ever valid while the main slot is valid.
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        logic [1:0] occ;
        case ({main_v, skid_v})
            2'b11:        occ = OCC_FULL;
            2'b10, 2'b01: occ = OCC_ONE;
            default:      occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// pipe_slot : one valid+ctrl+data holding register with load/drop/clear
// Rev 1.0
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 96,
    parameter int CTRL_W         = 8,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // A drop leaves data untouched; only a clear may zero it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (ZERO_ON_BUBBLE != 0) begin
                data_q <= '0;
            end
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (drop_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// pipe_stage_skid : generic pipeline register with valid/ready and 2-entry skid
// Rev 1.0
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 96,
    parameter int CTRL_W         = 8,
    parameter int ZERO_ON_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_main_valid, w_skid_valid;
    logic [CTRL_W-1:0] w_main_ctrl,  w_skid_ctrl;
    logic [DATA_W-1:0] w_main_data,  w_skid_data;

    logic              in_ready_q;
    logic              skid_valid_d;

    logic w_accept, w_consume, w_main_free;
    logic w_main_load, w_main_drop, w_skid_load, w_skid_drop;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    assign w_accept    = in_valid & in_ready_q;
    assign w_consume   = w_main_valid & out_ready;
    assign w_main_free = ~w_main_valid | w_consume;

    // Refill main from skid first so order stays FIFO.
    assign w_main_load    = ~flush & w_main_free & (w_skid_valid | w_accept);
    assign w_main_drop    = ~flush & w_main_free & ~w_skid_valid & ~w_accept;
    assign w_main_ctrl_in = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_in = w_skid_valid ? w_skid_data : in_data;

    assign w_skid_load = ~flush & ~w_main_free & w_accept;
    assign w_skid_drop = ~flush & w_main_free & w_skid_valid;

    always_comb begin
        skid_valid_d = w_skid_valid;
        if (flush || w_skid_drop) begin
            skid_valid_d = 1'b0;
        end else if (w_skid_load) begin
            skid_valid_d = 1'b1;
        end
    end

    // Ready is a flop fed from the next skid state: no combinational ready path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= ~skid_valid_d;
        end
    end

    pipe_slot #(
        .DATA_W         (DATA_W),
        .CTRL_W         (CTRL_W),
        .ZERO_ON_BUBBLE (ZERO_ON_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (w_main_load),
        .drop_i  (w_main_drop),
        .ctrl_i  (w_main_ctrl_in),
        .data_i  (w_main_data_in),
        .valid_o (w_main_valid),
        .ctrl_o  (w_main_ctrl),
        .data_o  (w_main_data)
    );

    pipe_slot #(
        .DATA_W         (DATA_W),
        .CTRL_W         (CTRL_W),
        .ZERO_ON_BUBBLE (ZERO_ON_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (w_skid_load),
        .drop_i  (w_skid_drop),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (w_skid_valid),
        .ctrl_o  (w_skid_ctrl),
        .data_o  (w_skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign out_data  = w_main_data;
    assign occupancy = occ_count(w_main_valid, w_skid_valid);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_skid : directed vector table plus randomized queue-model run
// Rev 1.0
// ============================================================================
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [95:0] in_data = '0;

    logic        ir1, ov1, ir0, ov0;
    logic [7:0]  oc1, oc0;
    logic [95:0] od1, od0;
    logic [1:0]  occ1, occ0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(96), .CTRL_W(8), .ZERO_ON_BUBBLE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_skid #(.DATA_W(96), .CTRL_W(8), .ZERO_ON_BUBBLE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  ic;
        logic [95:0] id;
        logic        ordy;
        logic        ov;
        logic [7:0]  oc;
        logic [95:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    typedef struct {
        logic [7:0]  c;
        logic [95:0] d;
    } entry_t;

    vec_t   vecs[$];
    entry_t q[$];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] ic, logic [95:0] id, logic ordy,
                                logic ov, logic [7:0] oc, logic [95:0] od, logic [1:0] occ, logic ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.ov = ov; v.oc = oc; v.od = od; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    initial begin
        // reset held with input activity
        rst = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = '1; out_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_ov",  96'(ov1),  96'(0));
        chk("rst_oc",  96'(oc1),  96'(0));
        chk("rst_od",  od1,       96'(0));
        chk("rst_ir",  96'(ir1),  96'(1));
        chk("rst_occ", 96'(occ1), 96'(0));
        chk("rst_od0", od0,       96'(0));
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        cyc();

        vecs.push_back(mk(0,1,8'h11,96'h1234,1, 1,8'h11,96'h1234,1,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,   1, 0,8'h00,96'h1234,0,1));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(0,1,8'(8'h20+k),96'(k),1, 1,8'(8'h20+k),96'(k),1,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 0,8'h00,96'h5,0,1));
        // stall and skid
        vecs.push_back(mk(0,1,8'hA1,96'hA,0, 1,8'hA1,96'hA,2'd1,1));
        vecs.push_back(mk(0,1,8'hB1,96'hB,0, 1,8'hA1,96'hA,2'd2,0));
        vecs.push_back(mk(0,1,8'hEE,96'hEE,0,1,8'hA1,96'hA,2'd2,0));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 1,8'hB1,96'hB,2'd1,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 0,8'h00,96'hB,2'd0,1));
        // flush when full, C must never appear
        vecs.push_back(mk(0,1,8'hA1,96'hA,0, 1,8'hA1,96'hA,2'd1,1));
        vecs.push_back(mk(0,1,8'hB1,96'hB,0, 1,8'hA1,96'hA,2'd2,0));
        vecs.push_back(mk(1,1,8'hC1,96'hC,0, 0,8'h00,96'h0,2'd0,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 0,8'h00,96'h0,2'd0,1));
        // flush with in_ready=1 drops the presented entry
        vecs.push_back(mk(0,1,8'hD1,96'hD,0, 1,8'hD1,96'hD,2'd1,1));
        vecs.push_back(mk(1,1,8'hE1,96'hE,1, 0,8'h00,96'h0,2'd0,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 0,8'h00,96'h0,2'd0,1));
        // simultaneous accept and consume at occupancy 1
        vecs.push_back(mk(0,1,8'hF1,96'hF,1, 1,8'hF1,96'hF,2'd1,1));
        vecs.push_back(mk(0,1,8'h71,96'h17,1,1,8'h71,96'h17,2'd1,1));
        vecs.push_back(mk(0,0,8'h00,96'h0,1, 0,8'h00,96'h17,2'd0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_ctrl = vecs[i].ic;
            in_data = vecs[i].id; out_ready = vecs[i].ordy;
            cyc();
            chk($sformatf("v%0d_ov", i),  96'(ov1),  96'(vecs[i].ov));
            chk($sformatf("v%0d_oc", i),  96'(oc1),  96'(vecs[i].oc));
            chk($sformatf("v%0d_od", i),  od1,       vecs[i].od);
            chk($sformatf("v%0d_occ", i), 96'(occ1), 96'(vecs[i].occ));
            chk($sformatf("v%0d_ir", i),  96'(ir1),  96'(vecs[i].ir));
            chk($sformatf("v%0d_ov0", i), 96'(ov0),  96'(vecs[i].ov));
            chk($sformatf("v%0d_oc0", i), 96'(oc0),  96'(vecs[i].oc));
            chk($sformatf("v%0d_occ0", i),96'(occ0), 96'(vecs[i].occ));
            chk($sformatf("v%0d_ir0", i), 96'(ir0),  96'(vecs[i].ir));
            if (vecs[i].ov) chk($sformatf("v%0d_od0", i), od0, vecs[i].od);
        end

        // flushed bubble keeps data only when ZERO_ON_BUBBLE=0
        flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 96'hABCD; out_ready = 1'b0;
        cyc();
        chk("zob_load_ov0", 96'(ov0), 96'(1));
        flush = 1'b1; in_valid = 1'b0;
        cyc();
        chk("zob0_ov", 96'(ov0), 96'(0));
        chk("zob0_oc", 96'(oc0), 96'(0));
        chk("zob0_od", od0,      96'hABCD);
        chk("zob1_od", od1,      96'(0));
        chk("zob1_oc", 96'(oc1), 96'(0));
        flush = 1'b0;

        // asynchronous reset between clock edges
        in_valid = 1'b1; in_ctrl = 8'h3C; in_data = 96'h77; out_ready = 1'b0;
        cyc();
        in_valid = 1'b1; in_data = 96'h78;
        cyc();
        chk("ar_pre_occ", 96'(occ1), 96'(2));
        #2 rst = 1'b0;
        #1;
        chk("ar_ov",  96'(ov1),  96'(0));
        chk("ar_occ", 96'(occ1), 96'(0));
        chk("ar_ir",  96'(ir1),  96'(1));
        chk("ar_od0", od0,       96'(0));
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // randomized run against a queue model
        begin
            logic [95:0] last1, last0;
            int          seq;
            logic        fl, iv, ordy, acc, cons;
            logic [7:0]  c;
            logic [95:0] d;
            last1 = '0; last0 = '0; seq = 0;
            q.delete();
            for (int n = 0; n < 10000; n++) begin
                fl   = ($urandom_range(0, 31) == 0);
                iv   = ($urandom_range(0, 99) < 60);
                ordy = ($urandom_range(0, 99) < 60);
                c    = 8'($urandom);
                d    = {32'($urandom), 32'($urandom), 32'(seq)};
                flush = fl; in_valid = iv; out_ready = ordy; in_ctrl = c; in_data = d;
                acc  = iv && (q.size() < 2);
                cons = ordy && (q.size() > 0);
                cyc();
                if (cons) void'(q.pop_front());
                if (fl) begin
                    q.delete();
                    last1 = '0;
                end else if (acc) begin
                    entry_t e;
                    e.c = c; e.d = d;
                    q.push_back(e);
                    seq++;
                end
                if (q.size() > 0) begin
                    last1 = q[0].d;
                    last0 = q[0].d;
                end
                chk("r_ov",   96'(ov1),  96'(q.size() > 0));
                chk("r_occ",  96'(occ1), 96'(q.size()));
                chk("r_ir",   96'(ir1),  96'(q.size() < 2));
                chk("r_oc",   96'(oc1),  96'((q.size() > 0) ? q[0].c : 8'h00));
                chk("r_od",   od1,       last1);
                chk("r_ov0",  96'(ov0),  96'(q.size() > 0));
                chk("r_occ0", 96'(occ0), 96'(q.size()));
                chk("r_oc0",  96'(oc0),  96'((q.size() > 0) ? q[0].c : 8'h00));
                chk("r_od0",  od0,       last0);
                if (!ov1) chk("r_bubble_ctrl", 96'(oc1), 96'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
